// File: rtl/fifo_frame_reader.sv
// ============================================================================
// fifo_frame_reader : FIFO read adapter -> registered valid/ready frame stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_frame_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 13,
   parameter int IDX_WIDTH  = 4,
   parameter int FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty_n,
   output logic                  fifo_deq,
   output logic                  fifo_clr,
   input  logic                  en,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  last_o,
   input  logic                  ready_i,
   output logic                  frame_done,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);

   localparam logic [IDX_WIDTH-1:0] c_IDX_LAST = IDX_WIDTH'(FRAME_LEN - 1);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_last;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic                  r_done;
   logic [FCNT_WIDTH-1:0] r_cnt;

   logic w_fire;
   logic w_idx_last;
   logic w_deq;

   assign w_fire     = r_valid & ready_i;
   assign w_idx_last = (r_idx == c_IDX_LAST);
   // A pop is allowed only when the single output slot is free or leaving now.
   assign w_deq      = rst_n & ~flush & en & fifo_empty_n & (~r_valid | ready_i);

   assign fifo_deq   = w_deq;
   assign fifo_clr   = flush;
   assign data_o     = r_data;
   assign valid_o    = r_valid;
   assign last_o     = r_last;
   assign frame_done = r_done;
   assign frame_cnt  = r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (flush) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
         end else if (w_deq) begin
            r_data  <= fifo_dout;
            r_valid <= 1'b1;
            r_last  <= w_idx_last;
            r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
         end else if (w_fire) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         // A last-word handshake during flush still counts, but is not pulsed.
         r_done <= w_fire & r_last & ~flush;
         if (w_fire & r_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// ============================================================================
// tb_fifo_frame_reader : randomized check against a queue-based reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_frame_reader;

   localparam int DW = 16;
   localparam int FL = 13;

   logic          clk;
   logic          rst_n, en, flush, ready_i, fifo_empty_n;
   logic [DW-1:0] fifo_dout;
   logic          fifo_deq, fifo_clr, valid_o, last_o, frame_done;
   logic [DW-1:0] data_o;
   logic [15:0]   frame_cnt;

   logic          w_rst_n, w_empty_n;
   logic [DW-1:0] w_dout;
   logic          w_deq, w_clr, w_valid, w_last, w_done;
   logic [DW-1:0] w_data;
   logic [1:0]    w_cnt;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: FIFO contents plus the observable output-stage view.
   logic [DW-1:0] q[$];
   bit            m_valid = 0;
   bit            m_last  = 0;
   bit            m_done  = 0;
   logic [DW-1:0] m_data  = '0;
   logic [15:0]   m_cnt   = '0;
   int unsigned   m_loaded = 0;

   fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .IDX_WIDTH(4), .FCNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty_n(fifo_empty_n),
      .fifo_deq(fifo_deq), .fifo_clr(fifo_clr), .en(en), .flush(flush),
      .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(2), .IDX_WIDTH(1), .FCNT_WIDTH(2)) u_wrap (
      .clk(clk), .rst_n(w_rst_n), .fifo_dout(w_dout), .fifo_empty_n(w_empty_n),
      .fifo_deq(w_deq), .fifo_clr(w_clr), .en(1'b1), .flush(1'b0),
      .data_o(w_data), .valid_o(w_valid), .last_o(w_last), .ready_i(1'b1),
      .frame_done(w_done), .frame_cnt(w_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs just after a falling edge, check the
   // combinational pop, advance the model, then check registered outputs.
   task automatic cycle(input logic i_rst_n, input logic i_en, input logic i_flush, input logic i_ready);
      bit exp_deq, fire, n_done;
      rst_n        = i_rst_n;
      en           = i_en;
      flush        = i_flush;
      ready_i      = i_ready;
      fifo_empty_n = (q.size() != 0);
      fifo_dout    = (q.size() != 0) ? q[0] : '0;
      #1;
      exp_deq = i_rst_n && !i_flush && i_en && (q.size() != 0) && (!m_valid || i_ready);
      check_eq("fifo_deq", {31'd0, fifo_deq}, {31'd0, exp_deq});
      check_eq("fifo_clr", {31'd0, fifo_clr}, {31'd0, i_flush});
      fire = m_valid && i_ready;
      if (!i_rst_n) begin
         m_valid = 0; m_last = 0; m_done = 0; m_data = '0; m_cnt = '0; m_loaded = 0;
         q.delete();
      end else begin
         n_done = fire && m_last && !i_flush;
         if (fire && m_last) m_cnt = m_cnt + 16'd1;
         if (i_flush) begin
            m_valid = 0; m_last = 0; m_loaded = 0;
            q.delete();
         end else if (exp_deq) begin
            m_data   = q.pop_front();
            m_valid  = 1;
            m_last   = ((m_loaded % FL) == FL - 1);
            m_loaded = m_loaded + 1;
         end else if (fire) begin
            m_valid = 0; m_last = 0;
         end
         m_done = n_done;
      end
      @(negedge clk);
      check_eq("valid_o",    {31'd0, valid_o},    {31'd0, m_valid});
      check_eq("last_o",     {31'd0, last_o},     {31'd0, m_last});
      check_eq("data_o",     {16'd0, data_o},     {16'd0, m_data});
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      check_eq("frame_cnt",  {16'd0, frame_cnt},  {16'd0, m_cnt});
   endtask

   initial begin
      int wn, pulses;
      rst_n = 0; en = 0; flush = 0; ready_i = 0; fifo_empty_n = 0; fifo_dout = '0;
      w_rst_n = 0; w_empty_n = 0; w_dout = '0;
      @(negedge clk);
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 1);

      // Streaming: 26 preloaded words, two full frames.
      for (int i = 0; i < 26; i++) q.push_back(DW'(i));
      for (int i = 0; i < 30; i++) cycle(1, 1, 0, 1);
      check_eq("stream_frame_cnt", {16'd0, frame_cnt}, 32'd2);

      // Backpressure, enable gating, underflow, flush and reset at random.
      for (int i = 0; i < 4000; i++) begin
         int n = $urandom_range(0, 2);
         if (q.size() > 40) n = 0;
         if ($urandom_range(0, 9) < 3) n = 0;
         for (int k = 0; k < n; k++) q.push_back(DW'($urandom));
         cycle(($urandom_range(0, 299) != 0),
               ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 7));
      end

      // Counter wrap on a 2-word frame, 2-bit counter: 1,2,3,0,1.
      w_rst_n = 1;
      wn      = 0;
      pulses  = 0;
      for (int c = 0; c < 40 && pulses < 5; c++) begin
         if (w_done) begin
            check_eq("wrap_cnt", {30'd0, w_cnt}, 32'((pulses + 1) % 4));
            pulses++;
         end
         w_empty_n = (wn < 10);
         w_dout    = DW'(wn);
         #1;
         if (w_deq) wn++;
         @(negedge clk);
      end
      check_eq("wrap_pulses", 32'(pulses), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
Read-side adapter for the team's `fifo` block. It drives the FIFO `deq`, consumes `dout`/`empty_n`, and presents the data as a registered valid/ready stream with frame framing (`last`) for downstream feature/CNN stages. It counts completed frames and supports a synchronous flush that also clears the attached FIFO.

Parameters:
DATA_WIDTH, 16, width of FIFO word and output data.
FRAME_LEN, 13, words per frame; must be >= 2.
IDX_WIDTH, 4, width of word index; must be >= $clog2(FRAME_LEN).
FCNT_WIDTH, 16, width of completed-frame counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
fifo_dout  input  DATA_WIDTH  FIFO head word; valid when fifo_empty_n=1.
fifo_empty_n  input  1  FIFO non-empty.
fifo_deq  output  1  pop FIFO head this cycle (combinational).
fifo_clr  output  1  clear request to FIFO (combinational copy of flush).
en  input  1  permit new pops; the held word is still presented when low.
flush  input  1  synchronous flush: drop held word, reset frame index, clear FIFO.
data_o  output  DATA_WIDTH  registered output word.
valid_o  output  1  data_o valid.
last_o  output  1  data_o is word FRAME_LEN-1 of its frame.
ready_i  input  1  downstream accepts when valid_o&ready_i.
frame_done  output  1  one-cycle pulse, cycle after the last-word handshake.
frame_cnt  output  FCNT_WIDTH  completed frames, wraps modulo 2^FCNT_WIDTH.

Behaviour:
- Reset (rst_n=0 at edge): valid_o=0, last_o=0, data_o=0, frame_done=0, frame_cnt=0, idx=0. fifo_deq=0 while rst_n=0.
- Output stage is a single register; held word and flags are stable while valid_o=1 and ready_i=0.
- fire = valid_o & ready_i.
- fifo_deq = rst_n & ~flush & en & fifo_empty_n & (~valid_o | ready_i). Full throughput: 1 word/cycle when the FIFO stays non-empty and ready_i=1.
- On fifo_deq at the edge:
  - data_o <= fifo_dout; valid_o <= 1.
  - last_o <= (idx == FRAME_LEN-1).
  - idx <= (idx == FRAME_LEN-1) ? 0 : idx+1.
- On fire without fifo_deq: valid_o <= 0, last_o <= 0; data_o holds its value.
- Latency: a word popped at edge N is visible on data_o after edge N; the first word is visible 1 cycle after fifo_empty_n rises, given en=1 and the stage empty.
- frame_done <= fire & last_o; frame_cnt increments by 1 on that same edge and wraps from all-ones to 0.
- idx counts words loaded, not handshakes. Framing is therefore fixed by FIFO order, independent of ready_i stalls.
- en=0: no pops. A held word remains until fired. idx is preserved, and framing resumes mid-frame when en returns.
- flush=1 at an edge:
  - valid_o <= 0, last_o <= 0, idx <= 0, fifo_deq=0, fifo_clr=1 in that cycle.
  - frame_done <= 0. A fire in the flush cycle is still counted in frame_cnt, but frame_done is forced 0.
  - frame_cnt is otherwise unchanged by flush.
- flush has priority over en and fifo_deq. rst_n has priority over everything.
- fifo_empty_n=0 with ready_i=1: the stage drains (valid_o=0 next cycle). No underflow: fifo_deq is never asserted while fifo_empty_n=0.
- Reset mid-frame: everything returns to reset values. The FIFO contents are the FIFO's responsibility (it shares rst_n).

Test Plan:
- Streaming: preload FIFO with 26 words 0x0000..0x0019, en=1, ready_i=1 -> data_o sequence 0x0000..0x0019 on consecutive cycles; last_o on 0x000C and 0x0019; two frame_done pulses; frame_cnt=2.
- Backpressure: ready_i toggling 1,0,0,1 with FIFO non-empty -> data_o/last_o stable while ready_i=0; no fifo_deq in stalled cycles; no word lost or duplicated over 13 words.
- Underflow: FIFO holds 5 words, then empty -> exactly 5 fifo_deq pulses, valid_o falls after the 5th fire; writing 8 more words completes the frame with last_o on the 13th word overall.
- Enable gating: en=0 after the 4th pop with word 3 held -> word 3 still delivered, no further pops; en=1 -> next word has idx 4 and last_o on the 13th word.
- Flush mid-frame: after 7 words, flush=1 for 1 cycle while valid_o=1 -> fifo_clr=1 that cycle, valid_o=0 next cycle, frame_cnt unchanged; the next 13 words form a full frame with last_o on the 13th.
- Counter wrap: FCNT_WIDTH=2, FRAME_LEN=2, stream 10 words -> frame_cnt sequence 1,2,3,0,1.
